// File: rtl/wisard_pkg.sv
// WISARD sequencer shared types: FSM encoding and gap constant.
// Overlap mode is selected by WISARD_SEQ_OVERLAP_EN.
package wisard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int GAP_W = 8;

  // Minimum spacing between core_eop pulses for a core with n classes.
  function automatic logic [GAP_W-1:0] gap_const(
    input int n_classes
  );
    return GAP_W'(n_classes + 3);
  endfunction

endpackage

// File: rtl/wisard_seq_if.sv
// WISARD sequencer bus: sample in, core stream, result out.
// Slave modport is the sequencer view.
interface wisard_seq_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int INDEX_WIDTH   = 3,
  parameter int N_RAMS        = 6,
  parameter int CLASS_WIDTH   = 2
);
  logic                            s_valid;
  logic                            s_ready;
  logic [N_RAMS*ADDRESS_WIDTH-1:0] s_data;
  logic                            core_sop;
  logic                            core_sink_valid;
  logic                            core_eop;
  logic [ADDRESS_WIDTH-1:0]        core_addr;
  logic [INDEX_WIDTH-1:0]          core_index;
  logic                            core_source_valid;
  logic [CLASS_WIDTH-1:0]          core_class;
  logic                            m_valid;
  logic                            m_ready;
  logic [CLASS_WIDTH-1:0]          m_class;
  logic                            busy;
  logic                            err;

  modport slave (
    input  s_valid, s_data,
    input  core_source_valid, core_class,
    input  m_ready,
    output s_ready,
    output core_sop, core_sink_valid, core_eop,
    output core_addr, core_index,
    output m_valid, m_class, busy, err
  );

  modport master (
    output s_valid, s_data,
    output core_source_valid, core_class,
    output m_ready,
    input  s_ready,
    input  core_sop, core_sink_valid, core_eop,
    input  core_addr, core_index,
    input  m_valid, m_class, busy, err
  );
endinterface

// File: rtl/wisard_res_fifo.sv
// Two-entry result FIFO between the classifier core and m_* stream.
// Head reads as zero while empty.
module wisard_res_fifo #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop)
        rp <= ~rp;
      cnt <= cnt + {1'b0, do_push}
                 - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/wisard_seq.sv
// WISARD sample sequencer: streams tuple addresses to the core.
// Define WISARD_SEQ_OVERLAP_EN to let a sample stream during search.
module wisard_seq
  import wisard_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int INDEX_WIDTH   = 3,
  parameter int N_RAMS        = 6,
  parameter int N_CLASSES     = 3,
  parameter int CLASS_WIDTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  wisard_seq_if.slave bus
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = INDEX_WIDTH;
  localparam int DW = N_RAMS * ADDRESS_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N_RAMS - 1);

  if (N_RAMS > 2**INDEX_WIDTH ||
      N_CLASSES > 2**CLASS_WIDTH) begin : g_bad_cfg
    $error("wisard_seq: bad parameters");
  end

  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    k;
  logic [IW-1:0]    k_nx;
  logic [DW-1:0]    sample;
  logic [1:0]       outst;
  logic             accept;
  logic             pop;
  logic             last;
  logic             gap_ok;
  logic             push;
  logic             full;
  logic             empty;
  logic             err_q;
  logic [CLASS_WIDTH-1:0] head;

`ifdef WISARD_SEQ_OVERLAP_EN
  localparam logic [1:0] LIMIT = 2'd2;
  logic [GAP_W-1:0] gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap <= '0;
    else if (bus.core_eop)
      gap <= gap_const(N_CLASSES);
    else if (gap != '0)
      gap <= gap - 1'b1;
  end

  assign gap_ok = (gap <= GAP_W'(N_RAMS));
`else
  localparam logic [1:0] LIMIT = 2'd1;
  assign gap_ok = 1'b1;
`endif

  assign last   = (k == LAST);
  assign accept = bus.s_valid & bus.s_ready;
  assign pop    = ~empty & bus.m_ready;

  assign bus.s_ready = rst_n & (state == IDLE)
                     & (outst < LIMIT) & gap_ok;

  always_comb begin
    state_nx = state;
    k_nx     = k;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = STREAM;
          k_nx     = '0;
        end
      end
      STREAM: begin
        if (last) begin
          state_nx = IDLE;
          k_nx     = '0;
        end else begin
          k_nx = k + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      sample <= '0;
      outst  <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      if (accept)
        sample <= bus.s_data;
      case ({accept, pop})
        2'b10:   outst <= outst + 2'd1;
        2'b01:   outst <= outst - 2'd1;
        default: outst <= outst;
      endcase
      if (bus.core_source_valid &
          (full | (outst == 2'd0)))
        err_q <= 1'b1;
    end
  end

  // Address/index are forced to zero outside a beat.
  always_comb begin
    bus.core_sink_valid = (state == STREAM);
    bus.core_sop   = bus.core_sink_valid & (k == '0);
    bus.core_eop   = bus.core_sink_valid & last;
    bus.core_index = bus.core_sink_valid ? k : '0;
    bus.core_addr  = '0;
    if (bus.core_sink_valid) begin
      for (int i = 0; i < N_RAMS; i++) begin
        if (k == IW'(i))
          bus.core_addr = sample[i*AW +: AW];
      end
    end
  end

  assign push = bus.core_source_valid
              & ~full & (outst != 2'd0);

  wisard_res_fifo #(
    .W (CLASS_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.core_class),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.m_valid = ~empty;
  assign bus.m_class = head;
  assign bus.busy    = (state != IDLE) | (outst != 2'd0);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_wisard_seq.sv
// Self-checking bench for wisard_seq (default and N_RAMS=1 builds).
// Honours WISARD_SEQ_OVERLAP_EN when defined.
module tb_wisard_seq;
  localparam int AW = 4;
  localparam int IW = 3;
  localparam int NR = 6;
  localparam int NC = 3;
  localparam int CW = 2;
  localparam int DW = NR * AW;
`ifdef WISARD_SEQ_OVERLAP_EN
  localparam int LIMIT = 2;
`else
  localparam int LIMIT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wisard_seq_if #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW),
    .N_RAMS        (NR),
    .CLASS_WIDTH   (CW)
  ) b0 ();

  wisard_seq_if #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW),
    .N_RAMS        (1),
    .CLASS_WIDTH   (CW)
  ) b1 ();

  wisard_seq #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW),
    .N_RAMS        (NR),
    .N_CLASSES     (NC),
    .CLASS_WIDTH   (CW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  wisard_seq #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW),
    .N_RAMS        (1),
    .N_CLASSES     (NC),
    .CLASS_WIDTH   (CW)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  // Reference: tuple k of a sample is nibble k counted from the LSB.
  function automatic logic [AW-1:0] exp_addr(
    input logic [DW-1:0] d,
    input int k
  );
    logic [DW-1:0] s;
    s = d >> (AW * k);
    return s[AW-1:0];
  endfunction

  function automatic logic [9:0] beat(
    input logic [DW-1:0] d,
    input int k
  );
    return {1'b1, k == 0, k == NR - 1,
            IW'(k), exp_addr(d, k)};
  endfunction

  task automatic idle_inputs();
    b0.s_valid = 1'b0;
    b0.s_data = '0;
    b0.core_source_valid = 1'b0;
    b0.core_class = '0;
    b0.m_ready = 1'b0;
    b1.s_valid = 1'b0;
    b1.s_data = '0;
    b1.core_source_valid = 1'b0;
    b1.core_class = '0;
    b1.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    got = {b0.s_ready, b0.core_sink_valid,
           b0.core_sop, b0.core_eop,
           b0.core_addr, b0.core_index,
           b0.m_valid, b0.m_class,
           b0.busy, b0.err};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b0.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1",
               b0.s_ready);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    logic [9:0] got;
    logic [9:0] exp;
    d = 24'hFEDCBA;
    checks++;
    if (b0.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b exp=1", b0.s_ready);
    end
    b0.s_valid = 1'b1;
    b0.s_data = d;
    @(negedge clk);
    b0.s_valid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      exp = beat(d, k);
      got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
             b0.core_index, b0.core_addr};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_beat%0d got=%h exp=%h",
                 k, got, exp);
      end
      @(negedge clk);
    end
    got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
           b0.core_index, b0.core_addr};
    checks++;
    if (got !== '0 || b0.busy !== 1'b1 || b0.err !== 1'b0)
    begin
      failures++;
      $display("FAIL single_after got=%h busy=%b err=%b exp=0/1/0",
               got, b0.busy, b0.err);
    end
  endtask

  task automatic test_result_handshake();
    b0.core_source_valid = 1'b1;
    b0.core_class = 2'd2;
    @(negedge clk);
    b0.core_source_valid = 1'b0;
    b0.core_class = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b0.m_valid, b0.m_class} !== 3'b110) begin
        failures++;
        $display("FAIL hold_result%0d got=%b%0d exp=1,2",
                 i, b0.m_valid, b0.m_class);
      end
      checks++;
      if (b0.s_ready !== (LIMIT > 1)) begin
        failures++;
        $display("FAIL hold_ready%0d got=%b exp=%b",
                 i, b0.s_ready, LIMIT > 1);
      end
      @(negedge clk);
    end
    b0.m_ready = 1'b1;
    @(negedge clk);
    b0.m_ready = 1'b0;
    checks++;
    if ({b0.m_valid, b0.s_ready, b0.busy} !== 3'b010) begin
      failures++;
      $display("FAIL after_pop got=%b exp=010",
               {b0.m_valid, b0.s_ready, b0.busy});
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [CW-1:0] cls;
    logic [9:0] got;
    logic [9:0] exp;
    int n;
    bit popped;
    for (int it = 0; it < 8; it++) begin
      d = DW'($urandom);
      cls = CW'($urandom_range(0, 3));
      n = 0;
      while (b0.s_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (b0.s_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_ready it=%0d got=%b exp=1",
                 it, b0.s_ready);
      end
      b0.s_valid = 1'b1;
      b0.s_data = d;
      @(negedge clk);
      b0.s_valid = 1'b0;
      for (int k = 0; k < NR; k++) begin
        exp = beat(d, k);
        got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
               b0.core_index, b0.core_addr};
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rand_beat it=%0d k=%0d got=%h exp=%h",
                   it, k, got, exp);
        end
        @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b0.core_source_valid = 1'b1;
      b0.core_class = cls;
      @(negedge clk);
      b0.core_source_valid = 1'b0;
      popped = 1'b0;
      n = 0;
      while (!popped && n < 30) begin
        b0.m_ready = 1'($urandom_range(0, 1));
        if (b0.m_valid && b0.m_ready) begin
          checks++;
          if (b0.m_class !== cls) begin
            failures++;
            $display("FAIL rand_class it=%0d got=%0d exp=%0d",
                     it, b0.m_class, cls);
          end
          popped = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      b0.m_ready = 1'b0;
      checks++;
      if (!popped || b0.busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_drain it=%0d popped=%b busy=%b exp=1/0",
                 it, popped, b0.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] smp [2];
    logic [CW-1:0] cls [2];
    logic [9:0] exp_q [$];
    logic [9:0] got;
    logic [9:0] e;
    int sop_t [$];
    int eop_t [$];
    int due [$];
    int sent;
    int nres;
    int ndel;
    smp[0] = DW'($urandom);
    smp[1] = DW'($urandom);
    cls[0] = 2'd1;
    cls[1] = 2'd3;
    sent = 0;
    nres = 0;
    ndel = 0;
    b0.m_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (b0.core_sink_valid) begin
        got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
               b0.core_index, b0.core_addr};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h0;
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL b2b_beat cyc=%0d got=%h exp=%h",
                   cyc, got, e);
        end
        if (b0.core_sop) sop_t.push_back(cyc);
        if (b0.core_eop) begin
          eop_t.push_back(cyc);
          due.push_back(cyc + NC + 1);
        end
      end
      if (b0.m_valid && b0.m_ready && ndel < 2) begin
        checks++;
        if (b0.m_class !== cls[ndel]) begin
          failures++;
          $display("FAIL b2b_order n=%0d got=%0d exp=%0d",
                   ndel, b0.m_class, cls[ndel]);
        end
        ndel++;
      end
      b0.core_source_valid = 1'b0;
      if (due.size() > 0 && due[0] == cyc && nres < 2) begin
        void'(due.pop_front());
        b0.core_source_valid = 1'b1;
        b0.core_class = cls[nres];
        nres++;
      end
      b0.s_valid = (sent < 2);
      if (sent < 2) begin
        b0.s_data = smp[sent];
        if (b0.s_ready) begin
          for (int k = 0; k < NR; k++)
            exp_q.push_back(beat(smp[sent], k));
          sent++;
        end
      end
    end
    idle_inputs();
    checks++;
    if (ndel != 2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_delivered got=%0d left=%0d exp=2/0",
               ndel, exp_q.size());
    end
    checks++;
    if (eop_t.size() != 2 ||
        eop_t[1] - eop_t[0] < NC + 3) begin
      failures++;
      $display("FAIL b2b_eop_gap n=%0d exp>=%0d",
               eop_t.size(), NC + 3);
    end
    checks++;
    if (sop_t.size() != 2 || eop_t.size() < 1 ||
        sop_t[1] - eop_t[0] < NC + 3 - NR) begin
      failures++;
      $display("FAIL b2b_sop_gap n=%0d exp>=%0d",
               sop_t.size(), NC + 3 - NR);
    end
`ifdef WISARD_SEQ_OVERLAP_EN
    checks++;
    if (sop_t.size() != 2 || eop_t.size() < 1 ||
        sop_t[1] >= eop_t[0] + NC + 2) begin
      failures++;
      $display("FAIL b2b_overlap n=%0d second sop too late",
               sop_t.size());
    end
`endif
  endtask

  task automatic test_unsolicited();
    checks++;
    if (b0.busy !== 1'b0) begin
      failures++;
      $display("FAIL unsol_idle busy=%b exp=0", b0.busy);
    end
    b0.core_source_valid = 1'b1;
    b0.core_class = 2'd1;
    @(negedge clk);
    b0.core_source_valid = 1'b0;
    checks++;
    if ({b0.err, b0.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL unsol_err got=%b exp=10",
               {b0.err, b0.m_valid});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({b0.err, b0.m_valid} !== 2'b10) begin
      failures++;
      $display("FAIL unsol_sticky got=%b exp=10",
               {b0.err, b0.m_valid});
    end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] d;
    logic [9:0] got;
    int n;
    d = DW'($urandom);
    b0.s_valid = 1'b1;
    b0.s_data = d;
    @(negedge clk);
    b0.s_valid = 1'b0;
    n = 0;
    while (!(b0.core_sink_valid && b0.core_index == 3) &&
           n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b0.core_index !== 3'd3) begin
      failures++;
      $display("FAIL mid_beat3 got=%0d exp=3", b0.core_index);
    end
    rst_n = 1'b0;
    #1;
    got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
           b0.core_index, b0.core_addr};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL mid_core_zero got=%h exp=0", got);
    end
    @(negedge clk);
    got = {b0.core_sink_valid, b0.core_sop, b0.core_eop,
           b0.core_index, b0.core_addr};
    checks++;
    if (got !== '0 || b0.busy !== 1'b0 ||
        b0.s_ready !== 1'b0 || b0.err !== 1'b0) begin
      failures++;
      $display("FAIL mid_in_reset core=%h busy=%b rdy=%b err=%b exp=0",
               got, b0.busy, b0.s_ready, b0.err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({b0.s_ready, b0.core_sink_valid, b0.busy} !== 3'b100)
      begin
        failures++;
        $display("FAIL mid_release%0d got=%b exp=100",
                 i, {b0.s_ready, b0.core_sink_valid, b0.busy});
      end
    end
  endtask

  task automatic test_n_rams1();
    logic [AW-1:0] d;
    logic [9:0] got;
    d = AW'($urandom_range(0, 15));
    checks++;
    if (b1.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL n1_ready got=%b exp=1", b1.s_ready);
    end
    b1.s_valid = 1'b1;
    b1.s_data = d;
    @(negedge clk);
    b1.s_valid = 1'b0;
    got = {b1.core_sink_valid, b1.core_sop, b1.core_eop,
           b1.core_index, b1.core_addr};
    checks++;
    if (got !== {3'b111, 3'd0, d}) begin
      failures++;
      $display("FAIL n1_beat got=%h exp=%h",
               got, {3'b111, 3'd0, d});
    end
    @(negedge clk);
    checks++;
    if ({b1.core_sink_valid, b1.busy} !== 2'b01) begin
      failures++;
      $display("FAIL n1_after got=%b exp=01",
               {b1.core_sink_valid, b1.busy});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_result_handshake();
    test_random();
    test_back_to_back();
    test_unsolicited();
    test_reset_midstream();
    test_n_rams1();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
